periph_obi_arbiter: RTL
=======================

Name: periph_obi_arbiter

Overview:
- Shares the single OBI slave port of the peripheral subsystem between NumMasters OBI requesters (e.g. core data port, DMA, debug), sitting immediately upstream of the peripheral subsystem's slave_req_i/slave_resp_o.
- Round-robin arbitration with OBI address-phase locking.
- In-order response routing via an outstanding-transaction ID FIFO.
- Flags protocol violations from the downstream slave.

Parameters:
- NumMasters, 2, number of requesting OBI masters (>=2).
- MaxOutstanding, 2, maximum granted-but-unanswered transactions (>=1); depth of the ID FIFO.
- IdxW, max(1,$clog2(NumMasters)), derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- master_req_i  in  obi_req_t[NumMasters]  per-master OBI request (req, addr, we, be, wdata).
- master_resp_o  out  obi_resp_t[NumMasters]  per-master OBI response (gnt, rvalid, rdata).
- slave_req_o  out  obi_req_t  to peripheral subsystem.
- slave_resp_i  in  obi_resp_t  from peripheral subsystem.
- outstanding_o  out  $clog2(MaxOutstanding+1)  current ID FIFO occupancy.
- err_o  out  1  sticky: rvalid received with no outstanding transaction.

Behaviour:
- Reset (rst_ni=0 at rising edge): state IDLE, rr_ptr=0, FIFO empty, err_o=0. Outputs in reset: slave_req_o.req=0, all gnt=0, all rvalid=0, all rdata=0, outstanding_o=0. A reset mid-transaction discards all outstanding IDs; later rvalids set err_o.
- Request path is combinational (0-cycle): slave_req_o fields = fields of the selected master. slave_req_o.req = master_req_i[sel].req & ~stall, where stall = FIFO full & ~pop.
- Grant: master_resp_o[sel].gnt = slave_resp_i.gnt & slave_req_o.req; all other gnt=0. Handshake fires when both are 1.
- State machine:
  - IDLE: sel = first requesting master scanning rr_ptr, rr_ptr+1, ... modulo NumMasters.
    - Handshake -> stay IDLE.
    - Requester present but no handshake (slave gnt=0 or stall) -> HOLD, latching sel into lock_idx.
  - HOLD: sel = lock_idx, regardless of other requesters; guarantees OBI addr/wdata stability until gnt.
    - Handshake -> IDLE.
    - Master drops req (protocol violation) -> IDLE, no err.
- On handshake: push sel into FIFO; rr_ptr <= (sel+1) mod NumMasters (wrap from NumMasters-1 to 0).
- Response path: slave_resp_i.rvalid=1 with FIFO non-empty -> pop head h. master_resp_o[h].rvalid=1 and master_resp_o[h].rdata=slave_resp_i.rdata in the same cycle; all other rvalid=0 and rdata=0.
- rvalid with FIFO empty -> dropped, err_o <= 1 (stays 1 until reset).
- Simultaneous push+pop: pop first, then push. Allowed when FIFO full, so throughput stays 1/cycle at full depth. Occupancy unchanged.
- Full with no pop: stall; slave_req_o.req=0 and no gnt. State goes to/stays in HOLD if a requester is present.
- A grant and a response for the same ID never occur in the same cycle (OBI rvalid >=1 cycle after gnt). An rvalid in the handshake cycle with an empty FIFO is therefore an error.
- outstanding_o is the registered occupancy count, range 0..MaxOutstanding.

Decomposition:
- Types: obi_pkg::obi_req_t and obi_resp_t; no new package types.
- IdxW and the count width are localparams in the module.
- One sub-module: periph_arb_id_fifo, a synchronous FIFO of IdxW-bit entries, depth MaxOutstanding.
  - Interface: push/pop/full/empty/count/head.
  - Pop-before-push when full.
  - Synchronous active-low reset to empty.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with all masters requesting -> slave_req_o.req=0, all gnt/rvalid=0, outstanding_o=0, err_o=0.
- Round-robin: masters 0 and 1 request continuously, slave gnt=1, rvalid 1 cycle later -> grants alternate 0,1,0,1; rdata 0xA5A5_0000 returned on master 1's beat reaches only master 1.
- Lock: master 1 requests addr 0x2000_0010, slave gnt=0 for 4 cycles, master 0 requests from cycle 2 -> slave addr stays 0x2000_0010 all 4 cycles; master 1 is granted first, master 0 next.
- Full: MaxOutstanding=2, slave grants 2 requests with no rvalid -> 3rd request sees slave_req_o.req=0, outstanding_o=2. An rvalid with a simultaneous pending request -> pop and push in the same cycle, outstanding_o stays 2.
- In-order routing: grants to masters 1,0 back to back, then rvalids with rdata 0x11, 0x22 -> master 1 gets 0x11, master 0 gets 0x22.
- Spurious response: FIFO empty, slave drives rvalid=1 -> no master rvalid, err_o=1 next cycle and sticky until reset.

Source files
------------

// File: rtl/obi_pkg.sv
// -----------------------------------------------------------------------------
// obi_pkg
//   Shared OBI bus types used by the peripheral subsystem and its arbiter.
//   obi_req_t  : master -> slave address-phase bundle (req, addr, we, be, wdata)
//   obi_resp_t : slave -> master bundle (gnt, rvalid, rdata)
// -----------------------------------------------------------------------------
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/periph_arb_id_fifo.sv
// -----------------------------------------------------------------------------
// periph_arb_id_fifo
//   Synchronous FIFO holding the master index of each granted-but-unanswered
//   OBI transaction, so responses can be routed back in order.
//   Ports:
//     clk_i, rst_ni : clock, synchronous active-low reset (empties the FIFO)
//     push_i/data_i : enqueue data_i (accepted when not full, or when popping)
//     pop_i         : dequeue the head entry (ignored when empty)
//     full_o/empty_o: occupancy flags
//     count_o       : registered occupancy, 0..Depth
//     head_o        : oldest entry (valid when !empty_o)
// -----------------------------------------------------------------------------
module periph_arb_id_fifo #(
    parameter  int unsigned Depth = 2,
    parameter  int unsigned Width = 1,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_rd_ptr;
    logic [PtrW-1:0]  r_wr_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == CntW'(Depth));
    assign w_pop_ok  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok = push_i & (~full_o | w_pop_ok);

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];

endmodule

// File: rtl/periph_obi_arbiter.sv
// -----------------------------------------------------------------------------
// periph_obi_arbiter
//   Shares the peripheral subsystem's single OBI slave port between
//   NumMasters requesters. Round-robin arbitration; once a master is selected
//   but not granted, the selection is locked until its grant so the address
//   phase stays stable. Responses are routed in order via an ID FIFO.
//   Ports:
//     clk_i, rst_ni  : clock, synchronous active-low reset
//     master_req_i   : per-master OBI requests
//     master_resp_o  : per-master OBI responses (gnt, rvalid, rdata)
//     slave_req_o    : request forwarded to the peripheral subsystem
//     slave_resp_i   : response from the peripheral subsystem
//     outstanding_o  : granted-but-unanswered transaction count
//     err_o          : sticky flag, rvalid seen with nothing outstanding
// -----------------------------------------------------------------------------
module periph_obi_arbiter
    import obi_pkg::*;
#(
    parameter  int unsigned NumMasters     = 2,
    parameter  int unsigned MaxOutstanding = 2,
    localparam int unsigned IdxW           = (NumMasters > 1) ? $clog2(NumMasters) : 1,
    localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  obi_req_t  [NumMasters-1:0]  master_req_i,
    output obi_resp_t [NumMasters-1:0]  master_resp_o,
    output obi_req_t                    slave_req_o,
    input  obi_resp_t                   slave_resp_i,
    output logic      [CntW-1:0]        outstanding_o,
    output logic                        err_o
);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_HOLD
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [IdxW-1:0]   r_rr_ptr;
    logic [IdxW-1:0]   r_lock_idx;
    logic              r_err;

    logic [IdxW-1:0]   w_rr_sel;
    logic [IdxW-1:0]   w_cand;
    logic              w_found;
    int unsigned       w_scan;
    logic [IdxW-1:0]   w_sel;
    logic              w_sel_req;
    logic              w_req_out;
    logic              w_hs;
    logic              w_pop;
    logic              w_stall;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [IdxW-1:0]   w_head;

    // First requester at or after the round-robin pointer.
    always_comb begin
        w_rr_sel = r_rr_ptr;
        w_found  = 1'b0;
        w_scan   = 0;
        w_cand   = '0;
        for (int unsigned i = 0; i < NumMasters; i++) begin
            w_scan = (32'(r_rr_ptr) + i) % NumMasters;
            w_cand = IdxW'(w_scan);
            if (!w_found && master_req_i[w_cand].req) begin
                w_found  = 1'b1;
                w_rr_sel = w_cand;
            end
        end
    end

    assign w_sel     = (r_state == ST_HOLD) ? r_lock_idx : w_rr_sel;
    assign w_sel_req = master_req_i[w_sel].req;

    // A response this cycle frees a FIFO slot, so full alone does not stall.
    assign w_pop     = rst_ni & slave_resp_i.rvalid & ~w_fifo_empty;
    assign w_stall   = w_fifo_full & ~w_pop;
    assign w_req_out = rst_ni & w_sel_req & ~w_stall;
    assign w_hs      = w_req_out & slave_resp_i.gnt;

    always_comb begin
        slave_req_o     = master_req_i[w_sel];
        slave_req_o.req = w_req_out;
    end

    always_comb begin
        master_resp_o            = '0;
        master_resp_o[w_sel].gnt = w_hs;
        if (w_pop) begin
            master_resp_o[w_head].rvalid = 1'b1;
            master_resp_o[w_head].rdata  = slave_resp_i.rdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_sel_req && !w_hs) w_state_nxt = ST_HOLD;
            ST_HOLD: if (w_hs || !w_sel_req) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_HOLD) begin
                r_lock_idx <= w_sel;
            end
            if (w_hs) begin
                r_rr_ptr <= (w_sel == IdxW'(NumMasters - 1)) ? '0 : w_sel + 1'b1;
            end
            if (slave_resp_i.rvalid && w_fifo_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    periph_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_hs),
        .data_i  (w_sel),
        .pop_i   (w_pop),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (outstanding_o),
        .head_o  (w_head)
    );

    assign err_o = r_err;

endmodule
